// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the execute ALU: load-use hazard bubbles plus EX/MEM and MEM/WB operand forwarding.
// Build option: define ID_EX_FWD_EN for the forwarding muxes; without it every RAW hazard against EX or EX/MEM stalls instead.
module id_ex_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic [4:0]  id_rd,
    input  logic [31:0] id_rdata1,
    input  logic [31:0] id_rdata2,
    input  logic [31:0] id_imm,
    input  logic        id_alu_src,
    input  logic [3:0]  id_func,
    input  logic        id_reg_write,
    input  logic        id_mem_read,
    input  logic        id_mem_write,
    input  logic        flush,
    input  logic        exmem_reg_write,
    input  logic [4:0]  exmem_rd,
    input  logic [31:0] exmem_result,
    input  logic        memwb_reg_write,
    input  logic [4:0]  memwb_rd,
    input  logic [31:0] memwb_result,
    output logic [31:0] ex_in1,
    output logic [31:0] ex_in2,
    output logic [3:0]  ex_func,
    output logic [31:0] ex_store_data,
    output logic        ex_valid,
    output logic        ex_reg_write,
    output logic        ex_mem_read,
    output logic        ex_mem_write,
    output logic [4:0]  ex_rd,
    output logic        load_use_stall
);
    logic        r_vld_p1;
    logic        r_alu_src_p1;
    logic        r_reg_write_p1;
    logic        r_mem_read_p1;
    logic        r_mem_write_p1;
    logic [4:0]  r_rs_p1;
    logic [4:0]  r_rt_p1;
    logic [4:0]  r_rd_p1;
    logic [3:0]  r_func_p1;
    logic [31:0] r_rdata1_p1;
    logic [31:0] r_rdata2_p1;
    logic [31:0] r_imm_p1;

    logic        w_stall;
    logic        w_bubble;
    logic [31:0] w_fwd_a;
    logic [31:0] w_fwd_b;

`ifdef ID_EX_FWD_EN
    // Youngest producer wins; register 0 is hard-wired and never forwarded.
    function automatic logic [31:0] fwd_sel(
        input logic [4:0]  idx,
        input logic [31:0] regval,
        input logic        em_we,
        input logic [4:0]  em_rd,
        input logic [31:0] em_val,
        input logic        mw_we,
        input logic [4:0]  mw_rd,
        input logic [31:0] mw_val
    );
        if (em_we && (em_rd != 5'd0) && (em_rd == idx))
            return em_val;
        else if (mw_we && (mw_rd != 5'd0) && (mw_rd == idx))
            return mw_val;
        else
            return regval;
    endfunction

    assign w_fwd_a = fwd_sel(r_rs_p1, r_rdata1_p1, exmem_reg_write, exmem_rd, exmem_result,
                             memwb_reg_write, memwb_rd, memwb_result);
    assign w_fwd_b = fwd_sel(r_rt_p1, r_rdata2_p1, exmem_reg_write, exmem_rd, exmem_result,
                             memwb_reg_write, memwb_rd, memwb_result);

    // rt is compared even for I-type consumers: a spurious stall is cheaper than decoding usage.
    assign w_stall = id_valid & ~flush & r_vld_p1 & r_mem_read_p1 & (r_rd_p1 != 5'd0) &
                     ((r_rd_p1 == id_rs) | (r_rd_p1 == id_rt));
`else
    logic w_ex_hit;
    logic w_exmem_hit;
    logic w_unused;

    assign w_fwd_a = r_rdata1_p1;
    assign w_fwd_b = r_rdata2_p1;

    // Without forwarding, any producer still ahead of write-back blocks the reader.
    assign w_ex_hit    = r_vld_p1 & r_reg_write_p1 & (r_rd_p1 != 5'd0) &
                         ((r_rd_p1 == id_rs) | (r_rd_p1 == id_rt));
    assign w_exmem_hit = exmem_reg_write & (exmem_rd != 5'd0) &
                         ((exmem_rd == id_rs) | (exmem_rd == id_rt));
    assign w_stall     = id_valid & ~flush & (w_ex_hit | w_exmem_hit);

    assign w_unused = ^{exmem_result, memwb_reg_write, memwb_rd, memwb_result,
                        r_rs_p1, r_rt_p1, r_mem_write_p1};
`endif

    assign w_bubble = flush | w_stall;

    // ---- stage p1: ID/EX register ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst || w_bubble) begin
            r_vld_p1       <= 1'b0;
            r_alu_src_p1   <= 1'b0;
            r_reg_write_p1 <= 1'b0;
            r_mem_read_p1  <= 1'b0;
            r_mem_write_p1 <= 1'b0;
            r_rs_p1        <= 5'd0;
            r_rt_p1        <= 5'd0;
            r_rd_p1        <= 5'd0;
            r_func_p1      <= 4'd0;
            r_rdata1_p1    <= 32'd0;
            r_rdata2_p1    <= 32'd0;
            r_imm_p1       <= 32'd0;
        end else begin
            r_vld_p1       <= id_valid;
            r_alu_src_p1   <= id_alu_src;
            r_reg_write_p1 <= id_reg_write;
            r_mem_read_p1  <= id_mem_read;
            r_mem_write_p1 <= id_mem_write;
            r_rs_p1        <= id_rs;
            r_rt_p1        <= id_rt;
            r_rd_p1        <= id_rd;
            r_func_p1      <= id_func;
            r_rdata1_p1    <= id_rdata1;
            r_rdata2_p1    <= id_rdata2;
            r_imm_p1       <= id_imm;
        end
    end

    assign ex_in1         = w_fwd_a;
    assign ex_in2         = r_alu_src_p1 ? r_imm_p1 : w_fwd_b;
    assign ex_store_data  = w_fwd_b;
    assign ex_func        = r_func_p1;
    assign ex_valid       = r_vld_p1;
    assign ex_reg_write   = r_reg_write_p1;
    assign ex_mem_read    = r_mem_read_p1;
    assign ex_mem_write   = r_mem_write_p1;
    assign ex_rd          = r_rd_p1;
    assign load_use_stall = w_stall;

endmodule
